// File: rtl/vector_pack_stream.sv
// -----------------------------------------------------------------------------
// vector_pack_stream
//
// Byte-serial front end for the vector dot-product engine. A framed stream of
// ELEM_W-bit elements arrives over a valid/ready handshake. Each frame of
// exactly 2*N_ELEM bytes is assembled into two packed vectors:
//   bytes 0..N_ELEM-1          -> vector1 elements 0..N_ELEM-1
//   bytes N_ELEM..2*N_ELEM-1   -> vector2 elements 0..N_ELEM-1
// Up to two completed frames are held in a ping-pong buffer. They are
// presented downstream over a second valid/ready handshake. A frame whose
// in_last does not line up with its final byte is discarded and flagged.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_data    in   element byte (ELEM_W bits)
//   in_valid   in   in_data / in_last valid
//   in_last    in   final byte of a frame
//   in_ready   out  a byte can be accepted
//   vector1    out  packed first vector, element k at [ELEM_W*k +: ELEM_W]
//   vector2    out  packed second vector, same packing
//   out_valid  out  a completed frame is presented
//   out_ready  in   downstream takes the presented frame
//   frame_err  out  one-cycle pulse after a frame is discarded
//   err_count  out  saturating count of discarded frames
// -----------------------------------------------------------------------------
module vector_pack_stream #(
  parameter int N_ELEM = 10,
  parameter int ELEM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ELEM_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [N_ELEM*ELEM_W-1:0] vector1,
  output logic [N_ELEM*ELEM_W-1:0] vector2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic [7:0]               err_count
);

  localparam int FRAME_LEN = 2 * N_ELEM;
  localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] wcnt;       // byte position within the frame being filled
  logic [1:0]       occ;        // number of committed slots (0..2)
  logic             wptr;       // slot currently being filled
  logic             rptr;       // oldest committed slot

  logic accept;                 // byte handshake this cycle
  logic at_last_idx;            // current byte is the frame's final position
  logic commit;                 // well-formed frame completes this cycle
  logic discard;                // malformed frame detected this cycle
  logic pop;                    // downstream takes the presented frame
  logic show_slot;              // slot driven onto vector1/vector2

  assign in_ready    = (occ < 2'd2) && !reset;
  assign accept      = in_valid && in_ready;
  assign at_last_idx = (wcnt == LAST_IDX);
  assign commit      = accept && at_last_idx && in_last;
  // Malformed when in_last disagrees with the position: early last
  // (in_last before the final byte) or missing last (final byte without it).
  assign discard     = accept && (at_last_idx != in_last);

  assign out_valid   = (occ != 2'd0);
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt      <= '0;
      occ       <= 2'd0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      // Both a commit and a discard restart the byte position.
      if (accept) begin
        wcnt <= (at_last_idx || in_last) ? '0 : wcnt + 1'b1;
      end
      if (commit) begin
        wptr <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      // Commit and pop in the same cycle cancel out. A commit at occ == 2 is
      // impossible because in_ready is low there.
      occ       <= occ + {1'b0, commit} - {1'b0, pop};
      frame_err <= discard;
      if (discard && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame storage: two slots of FRAME_LEN bytes each.
  // These are plain registers, not a RAM. Reset must clear every slot, and
  // all 2*N_ELEM bytes of the presented slot are read in parallel.
  // ---------------------------------------------------------------------------
  logic [ELEM_W-1:0] slot_mem [2][FRAME_LEN];
  logic              wr_en    [2][FRAME_LEN];

  // Every accepted byte is written into the fill slot, even on a frame that
  // later turns out malformed. That slot is never shown and is not committed,
  // and the next frame overwrites every byte before its commit.
  for (genvar gs = 0; gs < 2; gs++) begin : g_slot_we
    for (genvar gb = 0; gb < FRAME_LEN; gb++) begin : g_byte_we
      assign wr_en[gs][gb] = accept && (wptr == 1'(gs)) && (wcnt == CNT_W'(gb));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < FRAME_LEN; b++) begin
          slot_mem[s][b] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < FRAME_LEN; b++) begin
          if (wr_en[s][b]) begin
            slot_mem[s][b] <= in_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection
  // With frames buffered, show the oldest committed slot (rptr). While the
  // buffer is empty, wptr == rptr and that slot may be filling. The other
  // slot holds the frame popped last (zero after reset), so show that one.
  // The slot being filled therefore never reaches the outputs.
  // ---------------------------------------------------------------------------
  assign show_slot = out_valid ? rptr : ~rptr;

  for (genvar gk = 0; gk < N_ELEM; gk++) begin : g_unpack
    assign vector1[ELEM_W*gk +: ELEM_W] = slot_mem[show_slot][gk];
    assign vector2[ELEM_W*gk +: ELEM_W] = slot_mem[show_slot][N_ELEM + gk];
  end

endmodule

// File: tb/tb_vector_pack_stream.sv
// -----------------------------------------------------------------------------
// tb_vector_pack_stream
// Directed bench for vector_pack_stream. Expected frames go onto a scoreboard
// queue when their stimulus starts. The queue is popped and compared whenever
// the DUT hands a frame downstream.
// -----------------------------------------------------------------------------
module tb_vector_pack_stream;

  localparam int N_ELEM = 10;
  localparam int ELEM_W = 8;
  localparam int VW     = N_ELEM * ELEM_W;

  typedef struct packed {
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
  } frame_t;

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [VW-1:0] vector1;
  logic [VW-1:0] vector2;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;
  logic [7:0]    err_count;

  vector_pack_stream #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .vector1   (vector1),
    .vector2   (vector2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     pop_cnt = 0;
  int     err_pulses = 0;
  frame_t sb[$];

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [7:0] base);
    frame_t f;
    logic [7:0] b;
    for (int k = 0; k < N_ELEM; k++) begin
      b = base + 8'(k);
      f.v1[8*k +: 8] = b;
      b = base + 8'(N_ELEM + k);
      f.v2[8*k +: 8] = b;
    end
    return f;
  endfunction

  // Output monitor: a frame presented with out_ready high is taken on the
  // next rising edge. Sampling is done on the falling edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      pop_cnt++;
      $display("pop %0d: v1=%h v2=%h", pop_cnt, vector1, vector2);
      if (sb.size() == 0) begin
        chk("unexpected_out", VW'(out_valid), VW'(0));
      end else begin
        frame_t e;
        e = sb.pop_front();
        chk("out_vector1", vector1, e.v1);
        chk("out_vector2", vector2, e.v2);
      end
    end
    if (!reset && frame_err) err_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one byte and hold it until accepted (bounded). Returns 1 ns after
  // the accepting edge with in_valid low.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int budget = 500;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        chk("in_ready_wait", VW'(in_ready), VW'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int nbytes, input int last_pos,
                            input bit expect_out);
    logic [7:0] b;
    if (expect_out) sb.push_back(model(base));
    for (int i = 0; i < nbytes; i++) begin
      b = base + 8'(i);
      send_byte(b, (i == last_pos));
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("drain_pending", VW'(sb.size()), VW'(0));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    err_pulses = 0;
  endtask

  int     p0;
  int     hold_bad;
  bit     bp_done;
  frame_t fa, fe;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_vector1", vector1, VW'(0));
    chk("rst_vector2", vector2, VW'(0));
    chk("rst_frame_err", VW'(frame_err), VW'(0));
    chk("rst_err_count", VW'(err_count), VW'(0));
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", VW'(in_ready), VW'(1));

    // Single frame, bytes 1..20
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'd1, 20, 19, 1'b1);
    chk("single_latency_valid", VW'(out_valid), VW'(1));
    @(posedge clk); #1;
    chk("single_valid_one_cycle", VW'(out_valid), VW'(0));
    chk("idle_shows_last_v1", vector1, model(8'd1).v1);
    chk("idle_shows_last_v2", vector2, model(8'd1).v2);
    chk("single_pops", VW'(pop_cnt - p0), VW'(1));
    chk("single_no_err", VW'(err_pulses), VW'(0));

    // Backpressure: three frames back-to-back with out_ready low
    out_ready = 1'b0;
    p0 = pop_cnt;
    bp_done = 1'b0;
    fork
      begin
        send_frame(8'h01, 20, 19, 1'b1);
        send_frame(8'h41, 20, 19, 1'b1);
        send_frame(8'h81, 20, 19, 1'b1);
        bp_done = 1'b1;
      end
    join_none
    repeat (45) @(posedge clk);
    #1;
    fa = model(8'h01);
    chk("bp_in_ready_low", VW'(in_ready), VW'(0));
    chk("bp_out_valid", VW'(out_valid), VW'(1));
    chk("bp_vector1_A", vector1, fa.v1);
    hold_bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (vector1 !== fa.v1 || vector2 !== fa.v2 || !out_valid) hold_bad++;
    end
    chk("bp_hold_stable", VW'(hold_bad), VW'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && !bp_done; c++) @(posedge clk);
    chk("bp_sender_done", VW'(bp_done), VW'(1));
    drain();
    chk("bp_pops", VW'(pop_cnt - p0), VW'(3));
    chk("bp_no_err", VW'(err_pulses), VW'(0));

    // Early last on byte 5, then a valid frame
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'h10, 5, 4, 1'b0);
    chk("early_err_pulse", VW'(frame_err), VW'(1));
    send_frame(8'h20, 20, 19, 1'b1);
    drain();
    chk("early_err_pulses", VW'(err_pulses), VW'(1));
    chk("early_err_count", VW'(err_count), VW'(1));
    chk("early_pops", VW'(pop_cnt - p0), VW'(1));

    // Missing last, then a valid frame
    do_reset();
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'h30, 20, -1, 1'b0);
    chk("missing_err_pulse", VW'(frame_err), VW'(1));
    chk("missing_no_valid", VW'(out_valid), VW'(0));
    send_frame(8'h50, 20, 19, 1'b1);
    drain();
    chk("missing_err_pulses", VW'(err_pulses), VW'(1));
    chk("missing_err_count", VW'(err_count), VW'(1));
    chk("missing_pops", VW'(pop_cnt - p0), VW'(1));

    // Commit and pop in the same cycle
    out_ready = 1'b0;
    p0 = pop_cnt;
    send_frame(8'h60, 20, 19, 1'b1);
    fe = model(8'h90);
    sb.push_back(fe);
    for (int i = 0; i < 19; i++) send_byte(8'h90 + 8'(i), 1'b0);
    out_ready = 1'b1;
    send_byte(8'h90 + 8'd19, 1'b1);
    chk("cp_valid_stays", VW'(out_valid), VW'(1));
    chk("cp_vector1_E", vector1, fe.v1);
    drain();
    chk("cp_pops", VW'(pop_cnt - p0), VW'(2));

    // Reset with one frame buffered and a partial frame in flight
    out_ready = 1'b0;
    send_frame(8'hA0, 20, 19, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    chk("pre_reset_valid", VW'(out_valid), VW'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", VW'(out_valid), VW'(0));
    chk("mid_rst_vector1", vector1, VW'(0));
    chk("mid_rst_vector2", vector2, VW'(0));
    chk("mid_rst_err_count", VW'(err_count), VW'(0));
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    err_pulses = 0;
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'hD0, 20, 19, 1'b1);
    drain();
    chk("post_rst_pops", VW'(pop_cnt - p0), VW'(1));
    chk("post_rst_no_err", VW'(err_pulses), VW'(0));
    chk("post_rst_err_count", VW'(err_count), VW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
